// File: rtl/fpu_normalise.sv
// ---------------------------------------------------------------------------
// fpu_normalise
//
// Iterative normaliser placed between the FPU multiply/add datapath and the
// rounding stage. An accepted operand is first shifted left one bit per cycle
// until the hidden bit is set or the exponent reaches EMIN. It is then shifted
// right one bit per cycle while the exponent is below EMIN, which produces
// denormals. The result is offered to the rounding stage on a valid/ready
// handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid               in_ready   block can accept operand
//   z_e_in     signed exponent (EXP_W)     z_m_in     mantissa incl. hidden bit
//   guard_in / round_in / sticky_in        incoming guard/round/sticky bits
//   out_valid  result valid                out_ready  round stage accepts
//   z_e_out    normalised exponent         z_m_out    27-bit mantissa, top 0
//   guard / round_bit / sticky             bits handed to the round stage
// ---------------------------------------------------------------------------
module fpu_normalise #(
   parameter int EXP_W = 10,
   parameter int MAN_W = 24,
   parameter int EMIN  = -126
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [EXP_W-1:0] z_e_in,
   input  logic [MAN_W-1:0]        z_m_in,
   input  logic                    guard_in,
   input  logic                    round_in,
   input  logic                    sticky_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [EXP_W-1:0] z_e_out,
   output logic [26:0]             z_m_out,
   output logic                    guard,
   output logic                    round_bit,
   output logic                    sticky
);

   localparam logic signed [EXP_W-1:0] EMIN_E = EXP_W'(EMIN);

   typedef enum logic [1:0] {
      IDLE,
      NORM_LEFT,
      NORM_RIGHT,
      DONE
   } state_t;

   state_t                    state_q, state_d;
   logic signed [EXP_W-1:0]   e_q, e_d;
   logic [MAN_W-1:0]          m_q, m_d;
   logic                      g_q, g_d;
   logic                      r_q, r_d;
   logic                      s_q, s_d;

   // State and working registers. Reset clears everything so an operand in
   // flight is simply dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         e_q     <= '0;
         m_q     <= '0;
         g_q     <= 1'b0;
         r_q     <= 1'b0;
         s_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         e_q     <= e_d;
         m_q     <= m_d;
         g_q     <= g_d;
         r_q     <= r_d;
         s_q     <= s_d;
      end
   end

   // Next-state and datapath. Each shifting state performs at most one
   // one-bit shift per cycle and spends one extra cycle deciding to leave.
   // A left shift can only happen while e > EMIN and stops at EMIN, so a
   // shifted operand always passes straight through the right phase.
   always_comb begin
      state_d = state_q;
      e_d     = e_q;
      m_d     = m_q;
      g_d     = g_q;
      r_d     = r_q;
      s_d     = s_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               e_d = z_e_in;
               m_d = z_m_in;
               g_d = guard_in;
               r_d = round_in;
               s_d = sticky_in;
               // A true zero has nothing to normalise; sticky alone does
               // not make the value non-zero.
               if (z_m_in == '0 && !guard_in && !round_in) begin
                  state_d = DONE;
               end else begin
                  state_d = NORM_LEFT;
               end
            end
         end
         NORM_LEFT: begin
            if (!m_q[MAN_W-1] && (e_q > EMIN_E)) begin
               e_d = e_q - EXP_W'(1);
               m_d = {m_q[MAN_W-2:0], g_q};
               g_d = r_q;
               r_d = 1'b0;
            end else begin
               state_d = NORM_RIGHT;
            end
         end
         NORM_RIGHT: begin
            // Bits falling off the round position are folded into sticky.
            if (e_q < EMIN_E) begin
               e_d = e_q + EXP_W'(1);
               m_d = m_q >> 1;
               g_d = m_q[0];
               r_d = g_q;
               s_d = s_q | r_q;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign z_e_out   = e_q;
   assign z_m_out   = {{(27-MAN_W){1'b0}}, m_q};
   assign guard     = g_q;
   assign round_bit = r_q;
   assign sticky    = s_q;

endmodule

// File: tb/tb_fpu_normalise.sv
// ---------------------------------------------------------------------------
// tb_fpu_normalise
//
// Self-checking bench for fpu_normalise: directed vector table, hand-written
// handshake/reset sequences, and randomized operands checked against a
// closed-form reference model (leading-zero count and masked right shift).
// ---------------------------------------------------------------------------
module tb_fpu_normalise;

   localparam int EXP_W = 10;
   localparam int MAN_W = 24;
   localparam int EMIN  = -126;

   logic                    clk;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [EXP_W-1:0] z_e_in;
   logic [MAN_W-1:0]        z_m_in;
   logic                    guard_in;
   logic                    round_in;
   logic                    sticky_in;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [EXP_W-1:0] z_e_out;
   logic [26:0]             z_m_out;
   logic                    guard;
   logic                    round_bit;
   logic                    sticky;

   int nCompared   = 0;
   int nMismatched = 0;

   fpu_normalise #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .EMIN  (EMIN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .z_e_in    (z_e_in),
      .z_m_in    (z_m_in),
      .guard_in  (guard_in),
      .round_in  (round_in),
      .sticky_in (sticky_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z_e_out   (z_e_out),
      .z_m_out   (z_m_out),
      .guard     (guard),
      .round_bit (round_bit),
      .sticky    (sticky)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    e;
      int    m;
      bit    g;
      bit    r;
      bit    s;
      int    expE;
      int    expM;
      bit    expG;
      bit    expR;
      bit    expS;
      int    expLat;
   } vec_t;

   vec_t vecs[5];

   // Single comparison: bumps the counters and reports a mismatch.
   task automatic checkValue(input string name, input longint act, input longint exp);
      nCompared++;
      if (act != exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Compares every data output against the expected result.
   task automatic checkOutput(input string tag, input int ee, input int em,
                              input bit eg, input bit er, input bit es);
      checkValue({tag, ".e"}, longint'($signed(z_e_out)), longint'(ee));
      checkValue({tag, ".m"}, longint'(z_m_out), longint'(em));
      checkValue({tag, ".g"}, longint'(guard), longint'(eg));
      checkValue({tag, ".r"}, longint'(round_bit), longint'(er));
      checkValue({tag, ".s"}, longint'(sticky), longint'(es));
   endtask

   // Presents one operand from IDLE, waits for the accept edge, then counts
   // clock edges after it until out_valid (bounded). Leaves the block in DONE.
   task automatic applyStimulus(input int e, input int m, input bit g, input bit r,
                                input bit s, output int lat);
      @(negedge clk);
      z_e_in    = EXP_W'(e);
      z_m_in    = MAN_W'(m);
      guard_in  = g;
      round_in  = r;
      sticky_in = s;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Pulses out_ready for one cycle so the block returns to IDLE.
   task automatic releaseResult();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // Reference model: left shift count is the leading-zero count of
   // {m,g,r} limited by the exponent headroom; the right shift is a single
   // wide shift with everything below the round bit collapsed into sticky.
   task automatic model(input int e, input int m, input bit g, input bit r, input bit s,
                        output int oe, output int om, output bit og, output bit orr,
                        output bit os, output int lat);
      logic [25:0] v;
      int          lz;
      int          k;
      int          j;
      v  = {m[23:0], g, r};
      oe = e;
      os = s;
      if (m[23:0] == 0 && !g && !r) begin
         om = m; og = g; orr = r; lat = 0;
         return;
      end
      lz = 1000;
      for (int i = 25; i >= 0; i--) begin
         if (v[i]) begin
            lz = 25 - i;
            break;
         end
      end
      k = (e > EMIN) ? ((lz < e - EMIN) ? lz : e - EMIN) : 0;
      v  = (k >= 26) ? 26'd0 : (v << k);
      oe = e - k;
      j  = (oe < EMIN) ? EMIN - oe : 0;
      if (j >= 26) begin
         os = os | (|v);
         v  = '0;
      end else if (j > 0) begin
         os = os | (|(v & ((26'd1 << j) - 26'd1)));
         v  = v >> j;
      end
      oe  = oe + j;
      om  = int'(v[25:2]);
      og  = v[1];
      orr = v[0];
      lat = k + j + 2;
   endtask

   initial begin
      int lat;
      int ee, em, elat;
      bit eg, er, es;
      logic signed [EXP_W-1:0] heldE;
      logic [26:0]             heldM;

      vecs[0] = '{"normal",   3,    32'h800000, 1, 0, 1, 3,    32'h800000, 1, 0, 1, 2};
      vecs[1] = '{"left1",    5,    32'h400000, 1, 1, 0, 4,    32'h800001, 1, 0, 0, 3};
      vecs[2] = '{"clamp",    -125, 32'h000010, 0, 0, 0, -126, 32'h000020, 0, 0, 0, 3};
      vecs[3] = '{"denorm",   -128, 32'h800000, 1, 1, 0, -126, 32'h200000, 0, 0, 1, 4};
      vecs[4] = '{"zero",     7,    0,          0, 0, 1, 7,    0,          0, 0, 1, 0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      z_e_in    = '0;
      z_m_in    = '0;
      guard_in  = 1'b0;
      round_in  = 1'b0;
      sticky_in = 1'b0;
      #12;
      checkValue("reset.in_ready", longint'(in_ready), 1);
      checkValue("reset.out_valid", longint'(out_valid), 0);
      checkOutput("reset", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].e, vecs[i].m, vecs[i].g, vecs[i].r, vecs[i].s, lat);
         checkValue({vecs[i].name, ".lat"}, longint'(lat), longint'(vecs[i].expLat));
         checkOutput(vecs[i].name, vecs[i].expE, vecs[i].expM,
                     vecs[i].expG, vecs[i].expR, vecs[i].expS);
         releaseResult();
      end

      // Hold in DONE with out_ready low, then show in_valid is ignored in the
      // release cycle and accepted in the following IDLE cycle.
      applyStimulus(7, 0, 0, 0, 0, lat);
      heldE = z_e_out;
      heldM = z_m_out;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkValue("hold.out_valid", longint'(out_valid), 1);
         checkValue("hold.in_ready", longint'(in_ready), 0);
         checkValue("hold.e", longint'($signed(z_e_out)), 7);
         checkValue("hold.m", longint'(z_m_out), 0);
      end
      out_ready = 1'b1;
      z_e_in    = EXP_W'(3);
      z_m_in    = MAN_W'(24'h800000);
      guard_in  = 1'b1;
      round_in  = 1'b0;
      sticky_in = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkValue("bubble.in_ready", longint'(in_ready), 1);
      checkValue("bubble.out_valid", longint'(out_valid), 0);
      @(negedge clk);
      in_valid = 1'b0;
      checkValue("bubble.accepted", longint'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      checkValue("bubble.lat", longint'(lat), 2);
      checkOutput("bubble", 3, 32'h800000, 1, 0, 1);
      releaseResult();

      // Reset in the middle of a long left shift.
      @(negedge clk);
      z_e_in    = EXP_W'(20);
      z_m_in    = MAN_W'(1);
      guard_in  = 1'b0;
      round_in  = 1'b0;
      sticky_in = 1'b0;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkValue("midreset.busy", longint'(in_ready), 0);
      #2 rst_n = 1'b0;
      #1;
      checkValue("midreset.out_valid", longint'(out_valid), 0);
      checkValue("midreset.in_ready", longint'(in_ready), 1);
      checkOutput("midreset", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(5, 32'h400000, 1, 1, 0, lat);
      checkValue("afterreset.lat", longint'(lat), 3);
      checkOutput("afterreset", 4, 32'h800001, 1, 0, 0);
      releaseResult();

      // Randomized operands against the reference model.
      for (int n = 0; n < 200; n++) begin
         int re, rm;
         bit rg, rr, rs;
         re = int'($urandom_range(0, 300)) - 200;
         rm = int'(($urandom >> $urandom_range(0, 31)) & 32'hFFFFFF);
         rg = 1'($urandom);
         rr = 1'($urandom);
         rs = 1'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            rm = 0; rg = 0; rr = 0;
         end
         model(re, rm, rg, rr, rs, ee, em, eg, er, es, elat);
         applyStimulus(re, rm, rg, rr, rs, lat);
         checkValue("rand.lat", longint'(lat), longint'(elat));
         checkOutput("rand", ee, em, eg, er, es);
         releaseResult();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
